// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack handshake and
// presents one instruction at a time to decode, with stall, redirect, HALT and timeout.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out,
  output logic        pc_we,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalted} state_e;

  localparam logic [7:0] TimerMax = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        pc_we_q, pc_we_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic        discard_q, discard_d;
  logic [7:0]  timer_q, timer_d;
  logic        slot_free;

  // The output slot can take new data if it is empty or decode takes it this cycle.
  assign slot_free = !valid_q || !stall;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q && stall;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pc_we_d   = 1'b0;
    halted_d  = halted_q;
    err_d     = err_q;
    discard_d = discard_q;
    timer_d   = timer_q;

    if (redirect_valid && !(state_q == StHalted && err_q)) begin
      pc_d     = {redirect_addr[31:2], 2'b00};
      pc_we_d  = 1'b1;
      valid_d  = 1'b0;
      timer_d  = '0;
      halted_d = 1'b0;
      state_d  = StFetch;
      // An outstanding request must complete before the new address may be issued.
      if (req_q && !imem_ack) begin
        discard_d = 1'b1;
      end else begin
        discard_d = 1'b0;
        req_d     = 1'b1;
        addr_d    = {redirect_addr[31:2], 2'b00};
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StFetch;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        StFetch: begin
          if (!req_q) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            timer_d = '0;
          end else if (!imem_ack) begin
            if (timer_q == TimerMax) begin
              err_d     = 1'b1;
              halted_d  = 1'b1;
              req_d     = 1'b0;
              discard_d = 1'b0;
              state_d   = StHalted;
            end else begin
              timer_d = timer_q + 8'd1;
            end
          end else if (discard_q) begin
            discard_d = 1'b0;
            timer_d   = '0;
            addr_d    = pc_q;
          end else if (slot_free) begin
            valid_d   = 1'b1;
            inst_d    = imem_data;
            inst_pc_d = addr_q;
            pc_d      = pc_q + 32'd4;
            pc_we_d   = 1'b1;
            timer_d   = '0;
            if (imem_data[31:25] == HALT_OPCODE) begin
              state_d  = StHalted;
              halted_d = 1'b1;
              req_d    = 1'b0;
            end else begin
              addr_d = pc_q + 32'd4;
            end
          end else begin
            // Slot still stalled: drop the word, park, and refetch the same pc later.
            timer_d = '0;
            req_d   = 1'b0;
            state_d = StHold;
          end
        end
        StHold: begin
          if (!stall) begin
            state_d = StFetch;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        StHalted: req_d = 1'b0;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      pc_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      pc_we_q   <= pc_we_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      timer_q   <= timer_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc_out     = pc_q;
  assign pc_we      = pc_we_q;
  assign halted     = halted_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: drives a small wait-state memory model from the bench
// and checks handshake, stall, redirect, HALT and timeout behaviour.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
  logic        pc_we;
  logic        halted;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;
  int wait_states = 0;
  int wait_cnt    = 0;
  bit no_ack      = 1'b0;

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .TIMEOUT    (16),
    .HALT_OPCODE(7'b1111111)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .pc_out        (pc_out),
    .pc_we         (pc_we),
    .halted        (halted),
    .fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0014: return 32'hA000_0001;
      32'h0000_0040: return 32'h1111_0040;
      32'h0000_0208: return 32'hFE00_0000;
      default:       return {a[24:0], 7'h13};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory answers after wait_states idle cycles of a request; driven at the negedge.
  task automatic mem_drive();
    if (imem_req && !no_ack) begin
      if (wait_cnt >= wait_states) begin
        imem_ack  = 1'b1;
        imem_data = mem_word(imem_addr);
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = '0;
        wait_cnt++;
      end
    end else begin
      imem_ack  = 1'b0;
      imem_data = '0;
      if (!imem_req) wait_cnt = 0;
    end
  endtask

  task automatic tick();
    mem_drive();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    imem_ack = 1'b0;
    imem_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_flags", {30'd0, halted, fetch_err}, 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    reset = 1'b1;
    tick();

    // Zero-wait memory: one request per cycle, addresses 0,4,8,12,16.
    for (int i = 0; i < 5; i++) begin
      check("seq_addr", imem_addr, 32'(4 * i));
      check("seq_req", 32'(imem_req), 32'd1);
      check("seq_pc_out", pc_out, 32'(4 * i));
      if (i == 0) begin
        check("seq_valid0", 32'(inst_valid), 32'd0);
        check("seq_pc_we0", 32'(pc_we), 32'd0);
      end else begin
        check("seq_valid", 32'(inst_valid), 32'd1);
        check("seq_pc_we", 32'(pc_we), 32'd1);
        check("seq_inst_pc", inst_pc, 32'(4 * (i - 1)));
        check("seq_inst", inst_out, mem_word(32'(4 * (i - 1))));
      end
      if (i == 4) wait_states = 3;
      tick();
    end

    // Three wait states at 0x10: address held for four request cycles.
    for (int w = 0; w < 3; w++) begin
      check("ws_addr", imem_addr, 32'h10);
      check("ws_req", 32'(imem_req), 32'd1);
      check("ws_valid", 32'(inst_valid), 32'd0);
      check("ws_err", 32'(fetch_err), 32'd0);
      tick();
    end
    check("ws_done_valid", 32'(inst_valid), 32'd1);
    check("ws_done_pc", inst_pc, 32'h10);
    check("ws_done_inst", inst_out, 32'h0000_0813);
    check("ws_done_pc_we", 32'(pc_we), 32'd1);
    wait_states = 0;
    tick();

    // Stall for five cycles while 0xA000_0001 sits in the slot.
    check("st_inst", inst_out, 32'hA000_0001);
    check("st_inst_pc", inst_pc, 32'h14);
    stall = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      check("st_req", 32'(imem_req), 32'd0);
      check("st_hold_inst", inst_out, 32'hA000_0001);
      check("st_hold_valid", 32'(inst_valid), 32'd1);
      tick();
    end
    stall = 1'b0;
    check("st_release_req", 32'(imem_req), 32'd0);
    tick();
    check("st_resume_req", 32'(imem_req), 32'd1);
    check("st_resume_addr", imem_addr, 32'h18);
    check("st_resume_valid", 32'(inst_valid), 32'd0);

    // Redirect while the 0x40 request is outstanding; late ack must be dropped.
    for (int k = 0; k < 30 && imem_addr != 32'h40; k++) tick();
    check("rd_reach_40", imem_addr, 32'h40);
    no_ack = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("rd_pc_out", pc_out, 32'h200);
    check("rd_pc_we", 32'(pc_we), 32'd1);
    check("rd_addr_held", imem_addr, 32'h40);
    check("rd_req_held", 32'(imem_req), 32'd1);
    check("rd_flush", 32'(inst_valid), 32'd0);
    tick();
    check("rd_wait_addr", imem_addr, 32'h40);
    check("rd_wait_pc_we", 32'(pc_we), 32'd0);
    no_ack = 1'b0;
    tick();
    check("rd_new_addr", imem_addr, 32'h200);
    check("rd_drop_valid", 32'(inst_valid), 32'd0);
    tick();
    check("rd_inst_pc", inst_pc, 32'h200);
    check("rd_inst", inst_out, 32'h0001_0013);
    check("rd_valid", 32'(inst_valid), 32'd1);
    tick();
    tick();

    // HALT opcode at 0x208.
    check("ht_inst", inst_out, 32'hFE00_0000);
    check("ht_inst_pc", inst_pc, 32'h208);
    check("ht_valid", 32'(inst_valid), 32'd1);
    check("ht_halted", 32'(halted), 32'd1);
    check("ht_req", 32'(imem_req), 32'd0);
    tick();
    check("ht_consumed", 32'(inst_valid), 32'd0);
    check("ht_still_req", 32'(imem_req), 32'd0);
    check("ht_pc_out", pc_out, 32'h20C);
    redirect_valid = 1'b1;
    redirect_addr = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("ht_resume_halted", 32'(halted), 32'd0);
    check("ht_resume_addr", imem_addr, 32'h80);
    check("ht_resume_req", 32'(imem_req), 32'd1);
    check("ht_resume_pc_we", 32'(pc_we), 32'd1);
    tick();
    check("ht_resume_inst_pc", inst_pc, 32'h80);

    // Memory never answers: error after 16 request cycles.
    no_ack = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("to_req", 32'(imem_req), 32'd1);
      check("to_err_low", 32'(fetch_err), 32'd0);
      tick();
    end
    check("to_err", 32'(fetch_err), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_req_off", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_addr = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("to_redir_pc", pc_out, 32'h84);
    check("to_redir_halted", 32'(halted), 32'd1);
    check("to_redir_req", 32'(imem_req), 32'd0);
    check("to_redir_pc_we", 32'(pc_we), 32'd0);
    reset = 1'b0;
    #1;
    check("to_rst_flags", {30'd0, halted, fetch_err}, 32'd0);
    check("to_rst_pc", pc_out, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
